// File: rtl/dm_be.sv
// rtl/dm_be.sv - 4 KiB byte-lane data memory with access-fault flag and saturating store counter
// Optional feature: define DM_READ_REG_EN for a registered, write-first read port.
module dm_be (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        err,
  output logic [15:0] wr_cnt
);

  logic [31:0] r_mem [0:1023];
  logic        r_err;
  logic [15:0] r_wr_cnt;

  logic [9:0]  w_idx;
  logic        w_in_range;
  logic        w_pair_ok;
  logic        w_fault;
  logic        w_commit;
  logic [31:0] w_mask;
  logic [31:0] w_old;
  logic [31:0] w_merged;

  assign w_idx      = addr[11:2];
  assign w_in_range = (addr[31:12] == 20'd0);

  always_comb begin
    w_pair_ok = 1'b0;
    case ({be, addr[1:0]})
      6'b1111_00, 6'b0011_00, 6'b1100_10,
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11: w_pair_ok = 1'b1;
      default:                                         w_pair_ok = 1'b0;
    endcase
  end

  assign w_fault  = (we | re) & (~w_pair_ok | (be == 4'b0000) | ~w_in_range);
  assign w_commit = we & ~w_fault;

  // Out-of-range addresses must never alias onto a real word.
  assign w_old    = w_in_range ? r_mem[w_idx] : 32'd0;
  assign w_mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign w_merged = (wdata & w_mask) | (w_old & ~w_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) r_mem[i] <= 32'd0;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err    <= 1'b0;
      r_wr_cnt <= 16'd0;
    end else begin
      if (we | re) r_err <= w_fault;
      if (w_commit && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign err    = r_err;
  assign wr_cnt = r_wr_cnt;

`ifdef DM_READ_REG_EN
  logic [31:0] r_rdata;

  // Write-first: a same-cycle store to the read word returns the merged value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if (re) begin
      r_rdata <= w_fault ? 32'd0 : (w_commit ? w_merged : w_old);
    end
  end

  assign rdata = r_rdata;
`else
  assign rdata = (reset && re && !w_fault) ? w_old : 32'd0;
`endif

endmodule
